// File: rtl/alu_pkg.sv
// alu_pkg: 3-bit opcode encoding shared by alu_core, alu_pipe and the bench
package alu_pkg;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU; in A,B,S -> out result, carry (borrow on SUB), eq/a_gt_b/b_gt_a unsigned compare
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       S,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             eq,
  output logic             a_gt_b,
  output logic             b_gt_a
);
  logic [WIDTH:0] sum, diff;
  logic           big;
  always_comb begin
    sum    = {1'b0, A} + {1'b0, B};
    diff   = {1'b0, A} - {1'b0, B};
    big    = B >= WIDTH'(WIDTH);
    carry  = 1'b0;
    result = '0;
    case (S)
      OP_ADD:  {carry, result} = sum;
      OP_SUB:  {carry, result} = diff;
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_XOR:  result = A ^ B;
      OP_NOT:  result = ~A;
      OP_SHL:  result = big ? '0 : A << B;
      default: result = big ? '0 : A >> B;
    endcase
    eq     = A == B;
    a_gt_b = A > B;
    b_gt_a = A < B;
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: 2-stage valid/ready ALU; in in_valid,A,B,S,out_ready -> out in_ready,out_valid,final_o,final_carry,EQ,A_GT_B,B_GT_A,op_count
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       S,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] final_o,
  output logic             final_carry,
  output logic             EQ,
  output logic             A_GT_B,
  output logic             B_GT_A,
  output logic [CNT_W-1:0] op_count
);
  logic             rdy_q, v1_q, v1_d, v2_q, v2_d, adv1, take;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, core_res;
  logic [2:0]       s_q, s_d;
  logic [3:0]       flg_q, flg_d, core_flg;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  alu_core #(.WIDTH(WIDTH)) u_core (
    .A     (a_q),
    .B     (b_q),
    .S     (s_q),
    .result(core_res),
    .carry (core_flg[3]),
    .eq    (core_flg[2]),
    .a_gt_b(core_flg[1]),
    .b_gt_a(core_flg[0])
  );
  // rdy_q keeps in_ready low through reset and rises on the first edge after it
  always_comb begin
    adv1     = v1_q & (~v2_q | out_ready);
    in_ready = rdy_q & (~v1_q | adv1);
    take     = in_valid & in_ready;
    v1_d     = take | (v1_q & ~adv1);
    a_d      = take ? A : a_q;
    b_d      = take ? B : b_q;
    s_d      = take ? S : s_q;
    v2_d     = adv1 | (v2_q & ~out_ready);
    res_d    = adv1 ? core_res : res_q;
    flg_d    = adv1 ? core_flg : flg_q;
    cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, v2_q & out_ready};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q <= 1'b0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      res_q <= '0;
      flg_q <= '0;
      cnt_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      res_q <= res_d;
      flg_q <= flg_d;
      cnt_q <= cnt_d;
    end
  end
  assign out_valid                         = v2_q;
  assign final_o                           = res_q;
  assign {final_carry, EQ, A_GT_B, B_GT_A} = flg_q;
  assign op_count                          = cnt_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe with per-scenario tasks
module tb_alu_pipe;
  import alu_pkg::*;
  localparam int W  = 8;
  localparam int CW = 16;
  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         eq;
    logic         gt;
    logic         lt;
  } exp_t;
  logic          clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0]  A = '0, B = '0;
  logic [2:0]    S = '0;
  logic          in_ready, out_valid, final_carry, EQ, A_GT_B, B_GT_A;
  logic [W-1:0]  final_o;
  logic [CW-1:0] op_count;
  exp_t          sb[$];
  exp_t          mon_e;
  int            checks = 0, errors = 0;
  alu_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .S          (S),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .final_o    (final_o),
    .final_carry(final_carry),
    .EQ         (EQ),
    .A_GT_B     (A_GT_B),
    .B_GT_A     (B_GT_A),
    .op_count   (op_count)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s);
    exp_t         m;
    logic [W:0]   w;
    m   = '0;
    w   = {1'b0, a} + {1'b0, b};
    case (s)
      OP_ADD: begin m.res = w[W-1:0]; m.c = w[W]; end
      OP_SUB: begin m.res = a - b; m.c = (a < b); end
      OP_AND: m.res = a & b;
      OP_OR:  m.res = a | b;
      OP_XOR: m.res = a ^ b;
      OP_NOT: m.res = ~a;
      OP_SHL: m.res = (b >= W) ? '0 : a << b;
      default: m.res = (b >= W) ? '0 : a >> b;
    endcase
    m.eq = (a == b);
    m.gt = (a > b);
    m.lt = (b > a);
    return m;
  endfunction
  // transfers happen at the next rising edge; inputs are stable at the falling edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got result %h with nothing expected", final_o);
      end else begin
        mon_e = sb.pop_front();
        if ({final_o, final_carry, EQ, A_GT_B, B_GT_A} !== mon_e) begin
          errors++;
          $display("FAIL sb_result: got %h c%b eq%b gt%b lt%b, expected %h c%b eq%b gt%b lt%b",
                   final_o, final_carry, EQ, A_GT_B, B_GT_A, mon_e.res, mon_e.c, mon_e.eq, mon_e.gt, mon_e.lt);
        end
      end
    end
    if (!rst && in_valid && in_ready) sb.push_back(model(A, B, S));
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", errors);
    $fatal(1, "watchdog");
  end
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s);
    A = a; B = b; S = s; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL issue_timeout: in_ready got 0 for 100 cycles, required 1");
    in_valid = 1'b0;
  endtask
  task automatic reset_pulse();
    rst = 1'b1; in_valid = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    #3;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (op_count !== '0) begin errors++; $display("FAIL rst_op_count: got %0d want 0", op_count); end
    checks++; if ({final_o, final_carry, EQ, A_GT_B, B_GT_A} !== '0) begin errors++; $display("FAIL rst_result: got %h want 0", {final_o, final_carry, EQ, A_GT_B, B_GT_A}); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_release_ready_early: got %b want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
  endtask
  task automatic test_add();
    out_ready = 1'b1;
    issue(8'hFF, 8'h01, OP_ADD);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid: got %b want 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency: out_valid got %b want 1", out_valid); end
    checks++; if ({final_o, final_carry, A_GT_B} !== {8'h00, 1'b1, 1'b1}) begin errors++; $display("FAIL add_result: got %h c%b gt%b want 00 c1 gt1", final_o, final_carry, A_GT_B); end
    @(posedge clk); #1;
  endtask
  task automatic test_sub();
    issue(8'h07, 8'h08, OP_SUB);
    @(posedge clk); #1;
    checks++; if ({final_o, final_carry, B_GT_A} !== {8'hFF, 1'b1, 1'b1}) begin errors++; $display("FAIL sub_result: got %h c%b lt%b want ff c1 lt1", final_o, final_carry, B_GT_A); end
    @(posedge clk); #1;
  endtask
  task automatic test_shift();
    issue(8'h01, 8'd8, OP_SHL);
    issue(8'h80, 8'd7, OP_SHR);
    checks++; if (final_o !== 8'h00) begin errors++; $display("FAIL shl_result: got %h want 00", final_o); end
    @(posedge clk); #1;
    checks++; if (final_o !== 8'h01) begin errors++; $display("FAIL shr_result: got %h want 01", final_o); end
    @(posedge clk); #1;
  endtask
  task automatic test_back_to_back();
    int run;
    bit seen;
    run = 0; seen = 1'b0;
    reset_pulse();
    out_ready = 1'b1;
    fork
      for (int i = 0; i < 10; i++)
        issue(W'($urandom), (i % 2 == 1) ? W'($urandom_range(0, 10)) : W'($urandom), 3'(i));
      for (int c = 0; c < 40 && !(seen && !out_valid); c++) begin
        @(negedge clk);
        if (out_valid) begin seen = 1'b1; run++; end
      end
    join
    checks++; if (run !== 10) begin errors++; $display("FAIL b2b_run: consecutive results got %0d want 10", run); end
    checks++; if (op_count !== 16'd10) begin errors++; $display("FAIL b2b_op_count: got %0d want 10", op_count); end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL b2b_pending: got %0d outstanding want 0", sb.size()); end
    @(posedge clk); #1;
  endtask
  task automatic test_backpressure();
    logic [W-1:0] pa[4], pb[4];
    logic [2:0]   ps[4];
    logic [W+4:0] snap;
    int           idx;
    for (int i = 0; i < 4; i++) begin pa[i] = W'($urandom); pb[i] = W'($urandom); ps[i] = 3'($urandom); end
    reset_pulse();
    out_ready = 1'b0;
    idx = 0; snap = '0;
    A = pa[0]; B = pb[0]; S = ps[0]; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: cycle %0d got %b want 0", c, in_ready); end
      end
      if (c == 2) begin
        snap = {out_valid, final_o, final_carry, EQ, A_GT_B, B_GT_A};
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
      end
      if (c > 2) begin
        checks++; if ({out_valid, final_o, final_carry, EQ, A_GT_B, B_GT_A} !== snap) begin errors++; $display("FAIL bp_hold: got %h want %h", {out_valid, final_o, final_carry, EQ, A_GT_B, B_GT_A}, snap); end
      end
      if (in_ready) idx++;
      @(posedge clk); #1;
      if (idx < 4) begin A = pa[idx]; B = pb[idx]; S = ps[idx]; end
    end
    checks++; if (idx !== 2) begin errors++; $display("FAIL bp_accepted: got %0d want 2", idx); end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk); #1;
      if (idx < 4) begin A = pa[idx]; B = pb[idx]; S = ps[idx]; end
    end
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL bp_pending: got %0d outstanding want 0", sb.size()); end
    checks++; if (op_count !== 16'd4) begin errors++; $display("FAIL bp_op_count: got %0d want 4", op_count); end
  endtask
  task automatic test_reset_flush();
    bit saw;
    saw = 1'b0;
    reset_pulse();
    out_ready = 1'b1;
    issue(8'h11, 8'h22, OP_ADD);
    issue(8'h33, 8'h44, OP_XOR);
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    checks++; if (op_count !== '0) begin errors++; $display("FAIL flush_op_count: got %0d want 0", op_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    sb.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL flush_stale: out_valid seen 1 after reset, required 0"); end
    @(posedge clk); #1;
    issue(8'h05, 8'h05, OP_AND);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL flush_recover: op_count got %0d want 1", op_count); end
  endtask
  task automatic test_random();
    bit done;
    done = 1'b0;
    reset_pulse();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          issue(W'($urandom), W'($urandom_range(0, 12)), 3'($urandom));
        end
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    join
    out_ready = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL rand_pending: got %0d outstanding want 0", sb.size()); end
    checks++; if (op_count !== 16'd40) begin errors++; $display("FAIL rand_op_count: got %0d want 40", op_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_drained: out_valid got %b want 0", out_valid); end
  endtask
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_back_to_back();
    test_backpressure();
    test_reset_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width in bits; legal values are 4 to 32.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the completed-operation counter.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: A, B and S are valid this cycle.
REQ-006 Port in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-007 Port A, input, WIDTH bits: operand A, unsigned.
REQ-008 Port B, input, WIDTH bits: operand B, unsigned.
REQ-009 Port S, input, 3 bits: opcode.
REQ-010 Port out_valid, output, 1 bit: the result ports hold a valid result.
REQ-011 Port out_ready, input, 1 bit: the consumer accepts the result this cycle.
REQ-012 Port final, output, WIDTH bits: the result.
REQ-013 Port final_carry, output, 1 bit: carry out, or borrow on subtraction.
REQ-014 Ports EQ, A_GT_B and B_GT_A, outputs, 1 bit each: unsigned comparison of the A and B that produced the result.
REQ-015 Port op_count, output, CNT_W bits: number of results delivered.

Function
REQ-016 A transfer SHALL occur on an input when in_valid and in_ready are both 1 at a rising edge; a transfer SHALL occur on the output when out_valid and out_ready are both 1.
REQ-017 Opcodes SHALL be: 000 ADD (A+B); 001 SUB (A-B); 010 AND; 011 OR; 100 XOR; 101 NOT A; 110 SHL (A shifted left by B); 111 SHR (A shifted right logically by B).
REQ-018 For ADD, final_carry SHALL be bit WIDTH of the (WIDTH+1)-bit sum; for SUB, final_carry SHALL be 1 exactly when A<B unsigned; for all other opcodes, final_carry SHALL be 0.
REQ-019 For SHL and SHR, a shift amount of B>=WIDTH SHALL give final=0; final SHALL otherwise be truncated to WIDTH bits with wrap-around.
REQ-020 Exactly one of EQ, A_GT_B and B_GT_A SHALL be 1 for every valid result, for every opcode.
REQ-021 The pipeline SHALL have two register stages: stage 1 captures the operands and opcode, and stage 2 captures the result and flags; latency from input transfer to out_valid SHALL be 2 cycles.
REQ-022 With out_ready held at 1, throughput SHALL be one operation per cycle with no bubbles.
REQ-023 in_ready SHALL be 1 when stage 1 is empty or stage 1 advances in the same cycle; stage 1 SHALL advance when stage 2 is empty or stage 2 transfers out in the same cycle.
REQ-024 While out_valid=1 and out_ready=0, final, final_carry, EQ, A_GT_B, B_GT_A and out_valid SHALL hold stable.
REQ-025 No operation SHALL be dropped or duplicated under any pattern of in_valid or out_ready.
REQ-026 When an input transfer and an output transfer occur in the same cycle, the pipeline SHALL stay full with no stall.
REQ-027 op_count SHALL increment by 1 on each output transfer and SHALL wrap from all-ones to 0.

Reset
REQ-028 While rst=1, both stage valid bits, out_valid and op_count SHALL be 0, and final, final_carry, EQ, A_GT_B and B_GT_A SHALL be 0, independent of clk.
REQ-029 in_ready SHALL be 0 while rst=1 and SHALL become 1 on the first clock edge after rst deasserts.
REQ-030 An rst assertion during operation SHALL discard every in-flight operation without emitting it.

Structure
REQ-031 A shared package alu_pkg SHALL hold the 3-bit opcode constants, shared by the RTL and the bench.
REQ-032 The combinational datapath SHALL be a sub-module alu_core (parameter WIDTH; inputs A, B, S; outputs result, carry and the three compare flags), instantiated once between stage 1 and stage 2.

Verification
REQ-033 The bench SHALL cover ADD with WIDTH=8, A=0xFF, B=0x01 -> final=0x00, final_carry=1, A_GT_B=1, out_valid 2 cycles after the transfer.
REQ-034 The bench SHALL cover SUB with A=0x07, B=0x08 -> final=0xFF, final_carry=1, B_GT_A=1.
REQ-035 The bench SHALL cover SHL with A=0x01, B=8 -> final=0x00, and SHR with A=0x80, B=7 -> final=0x01.
REQ-036 The bench SHALL cover a back-to-back run of 10 operations with out_ready=1 -> 10 results in order on consecutive cycles, with op_count=10.
REQ-037 The bench SHALL cover out_ready=0 for 5 cycles with continuous input -> in_ready=0 after 2 accepted operations, output held stable, and no loss after release.
REQ-038 The bench SHALL cover rst asserted with 2 operations in flight -> out_valid=0 immediately, op_count=0, and no stale result after reset.
